fdivsqrt_seq: RTL and testbench
===============================

Name: fdivsqrt_seq

Overview:
- Iteration controller for the digit-recurrence divide/sqrt datapath.
- Accepts a start request from the Execute stage and computes the required iteration count from the format/result width, using the same cycle rule as the divsqrt cycle calculator.
- Asserts the datapath iteration enable for exactly that many cycles, then signals completion and holds the result until the downstream stage accepts it.
- Handles special-case bypass, flush and stall.

Parameters:
- LOGFLEN, 6, width of Nf
- DIVBLEN, 7, width of integer result-bit count
- DURLEN, 5, width of the cycle counter
- LOGR, 2, log2 of radix (integer bits per digit)
- RK, 4, result bits produced per cycle (LOGR × copies)
- IDIV_ON_FPU, 1, integer divide shares this datapath

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- StartE  in  1  divide/sqrt request in Execute
- Nf  in  LOGFLEN  fractional bits of selected FP format
- IntDivE  in  1  request is integer divide
- IntResultBitsE  in  DIVBLEN  integer result bits needed
- SpecialCaseE  in  1  NaN/Inf/zero/div-by-zero; no iteration needed
- FlushE  in  1  pipeline flush
- StallM  in  1  Memory stage cannot accept result
- DivStartE  out  1  datapath initialise pulse
- IterEnE  out  1  datapath iteration enable
- FDivBusyE  out  1  unit occupied; stalls front end
- FDivDoneE  out  1  result valid
- StepCnt  out  DURLEN  iterations remaining

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset: state IDLE, StepCnt=0. All outputs 0.
- Cycle count (combinational, from current inputs):
  - FPBits = Nf+2+LOGR.
  - Bits = (IDIV_ON_FPU && IntDivE) ? IntResultBitsE : FPBits.
  - Cycles = (Bits-1)/RK+1.
  - Bits=0 forces Cycles=1.
  - Arithmetic is done at DIVBLEN width; the result is truncated to DURLEN.
- States: IDLE, BUSY, DONE.
- IDLE:
  - StartE & !FlushE & SpecialCaseE: go to DONE. No iteration.
  - StartE & !FlushE & !SpecialCaseE: DivStartE=1 combinationally this cycle. Load StepCnt=Cycles. Go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - IterEnE=1 and FDivBusyE=1.
  - StepCnt decrements each cycle.
  - When StepCnt==1: go to DONE (StepCnt becomes 0).
  - The BUSY dwell is therefore exactly Cycles clocks.
- DONE:
  - FDivDoneE=1.
  - FDivBusyE=StallM.
  - !StallM: go to IDLE.
  - StallM: hold DONE, with the result held.
- Flush: FlushE forces IDLE on the next edge from any state and clears StepCnt. Flush has priority over StartE, completion and StallM.
- Back-to-back: a new StartE is accepted only in IDLE. The earliest accept is the cycle after DONE is left. StartE in BUSY or DONE is ignored; the pipeline is stalled by FDivBusyE.
- Sampling: Nf, IntDivE and IntResultBitsE are sampled only in the accept cycle. Changes during BUSY have no effect.
- Reset mid-operation: immediate return to IDLE, outputs 0, no done pulse.
- Latency: accept edge to FDivDoneE = Cycles+1 edges. For a special case it is 1 edge.

Test Plan:
- Double FP (Nf=52, IntDivE=0), StartE 1 cycle -> DivStartE pulse; IterEnE high 14 cycles (56 bits); FDivDoneE on the 15th edge for 1 cycle; back to IDLE.
- Single FP (Nf=23) and half FP (Nf=10) -> IterEnE high 7 cycles and 4 cycles respectively.
- Integer divide, IntResultBitsE=64 -> 16 iterations. IntResultBitsE=1 -> 1 iteration. IntResultBitsE=0 -> 1 iteration.
- SpecialCaseE=1 with StartE -> no DivStartE, no IterEnE; FDivDoneE the next cycle.
- StallM high for 3 cycles in DONE -> FDivDoneE and FDivBusyE held 3 extra cycles; IDLE after StallM drops. StartE asserted during the stall is ignored.
- FlushE at BUSY iteration 5 of 14 -> IDLE next edge, StepCnt=0, no FDivDoneE. Async reset pulse mid-BUSY -> outputs 0 immediately.

Source files
------------

// File: rtl/fdivsqrt_seq.sv
// Iteration controller for the digit-recurrence divide/sqrt datapath.
// Sequences start, iteration count, completion handshake, flush and stall.
//
// state | meaning
// IDLE  | waiting for a request; StepCnt held at 0
// BUSY  | datapath iterating; StepCnt counts remaining iterations down to 1
// DONE  | result valid; held while StallM is asserted
module fdivsqrt_seq #(
    parameter int LOGFLEN     = 6,
    parameter int DIVBLEN     = 7,
    parameter int DURLEN      = 5,
    parameter int LOGR        = 2,
    parameter int RK          = 4,
    parameter int IDIV_ON_FPU = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StartE,
    input  logic [LOGFLEN-1:0] Nf,
    input  logic               IntDivE,
    input  logic [DIVBLEN-1:0] IntResultBitsE,
    input  logic               SpecialCaseE,
    input  logic               FlushE,
    input  logic               StallM,
    output logic               DivStartE,
    output logic               IterEnE,
    output logic               FDivBusyE,
    output logic               FDivDoneE,
    output logic [DURLEN-1:0]  StepCnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DIVBLEN-1:0] RK_W       = DIVBLEN'(RK);
    localparam logic [DIVBLEN-1:0] FP_EXTRA_W = DIVBLEN'(2 + LOGR);
    localparam logic [DIVBLEN-1:0] ONE_W      = DIVBLEN'(1);

    state_t             state, state_nxt;
    logic [DURLEN-1:0]  step_cnt_nxt;
    logic [DIVBLEN-1:0] fp_bits;
    logic [DIVBLEN-1:0] bits;
    logic [DIVBLEN-1:0] cycles_full;
    logic [DURLEN-1:0]  cycles;

    // Iterations = ceil(bits / RK), with zero bits still costing one pass.
    always_comb begin
        fp_bits     = DIVBLEN'(Nf) + FP_EXTRA_W;
        bits        = ((IDIV_ON_FPU != 0) && IntDivE) ? IntResultBitsE : fp_bits;
        cycles_full = (bits == '0) ? ONE_W : ((bits - ONE_W) / RK_W) + ONE_W;
        cycles      = DURLEN'(cycles_full);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            StepCnt <= '0;
        end else begin
            state   <= state_nxt;
            StepCnt <= step_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        step_cnt_nxt = StepCnt;
        DivStartE    = 1'b0;
        IterEnE      = 1'b0;
        FDivBusyE    = 1'b0;
        FDivDoneE    = 1'b0;

        case (state)
            IDLE: begin
                if (StartE && !FlushE) begin
                    if (SpecialCaseE) begin
                        state_nxt = DONE;
                    end else begin
                        DivStartE    = !reset;
                        step_cnt_nxt = cycles;
                        state_nxt    = BUSY;
                    end
                end
            end
            BUSY: begin
                IterEnE      = 1'b1;
                FDivBusyE    = 1'b1;
                step_cnt_nxt = StepCnt - 1'b1;
                if (StepCnt == DURLEN'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                FDivDoneE = 1'b1;
                FDivBusyE = StallM;
                if (!StallM) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt    = IDLE;
                step_cnt_nxt = '0;
            end
        endcase

        // Flush wins over start, completion and stall.
        if (FlushE) begin
            state_nxt    = IDLE;
            step_cnt_nxt = '0;
        end
    end

endmodule

// File: tb/tb_fdivsqrt_seq.sv
// Self-checking bench for fdivsqrt_seq: directed cases plus randomized
// requests compared against a ceil(bits/RK) iteration model.
module tb_fdivsqrt_seq;

    localparam int LOGR = 2;
    localparam int RK   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       StartE;
    logic [5:0] Nf;
    logic       IntDivE;
    logic [6:0] IntResultBitsE;
    logic       SpecialCaseE;
    logic       FlushE;
    logic       StallM;
    logic       DivStartE;
    logic       IterEnE;
    logic       FDivBusyE;
    logic       FDivDoneE;
    logic [4:0] StepCnt;

    int passed = 0;
    int total  = 0;

    fdivsqrt_seq dut (
        .clk            (clk),
        .reset          (reset),
        .StartE         (StartE),
        .Nf             (Nf),
        .IntDivE        (IntDivE),
        .IntResultBitsE (IntResultBitsE),
        .SpecialCaseE   (SpecialCaseE),
        .FlushE         (FlushE),
        .StallM         (StallM),
        .DivStartE      (DivStartE),
        .IterEnE        (IterEnE),
        .FDivBusyE      (FDivBusyE),
        .FDivDoneE      (FDivDoneE),
        .StepCnt        (StepCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Number of radix-2^LOGR passes needed to produce the requested bits.
    function automatic int model_cycles(input int nf, input bit intdiv, input int irb);
        int b;
        b = intdiv ? irb : nf + 2 + LOGR;
        if (b == 0) return 1;
        return (b + RK - 1) / RK;
    endfunction

    function automatic logic [31:0] all_outs();
        return 32'({DivStartE, IterEnE, FDivBusyE, FDivDoneE, StepCnt});
    endfunction

    task automatic run_op(input string tag, input int nf, input bit intdiv, input int irb,
                          input bit special, input int stall);
        int cyc, iters, dcnt, guard;
        cyc = special ? 0 : model_cycles(nf, intdiv, irb);
        @(negedge clk);
        Nf             = 6'(nf);
        IntDivE        = intdiv;
        IntResultBitsE = 7'(irb);
        SpecialCaseE   = special;
        StartE         = 1'b1;
        #1;
        chk({tag, ".divstart"}, 32'(DivStartE), 32'(!special));
        chk({tag, ".idle_busy"}, 32'(FDivBusyE), 32'(0));
        @(negedge clk);
        StartE       = 1'b0;
        SpecialCaseE = 1'b0;
        iters = 0;
        guard = 0;
        while (IterEnE === 1'b1 && guard < 100) begin
            chk({tag, ".stepcnt"}, 32'(StepCnt), 32'(cyc - iters));
            chk({tag, ".busy"}, 32'(FDivBusyE), 32'(1));
            chk({tag, ".nodivstart"}, 32'(DivStartE), 32'(0));
            // operands must already be captured; scramble them
            Nf             = 6'($urandom);
            IntDivE        = 1'($urandom);
            IntResultBitsE = 7'($urandom);
            iters++;
            guard++;
            @(negedge clk);
        end
        chk({tag, ".iters"}, 32'(iters), 32'(cyc));
        dcnt  = 0;
        guard = 0;
        while (FDivDoneE === 1'b1 && guard < 20) begin
            StallM = (dcnt < stall);
            StartE = (dcnt < stall);
            #1;
            chk({tag, ".done_busy"}, 32'(FDivBusyE), 32'(StallM));
            chk({tag, ".done_stepcnt"}, 32'(StepCnt), 32'(0));
            chk({tag, ".done_noiter"}, 32'({DivStartE, IterEnE}), 32'(0));
            dcnt++;
            guard++;
            @(negedge clk);
        end
        StallM = 1'b0;
        StartE = 1'b0;
        chk({tag, ".done_cycles"}, 32'(dcnt), 32'(stall + 1));
        #1;
        chk({tag, ".back_idle"}, all_outs(), 32'(0));
    endtask

    initial begin
        int dones;
        reset = 1'b1;
        StartE = 1'b0; Nf = '0; IntDivE = 1'b0; IntResultBitsE = '0;
        SpecialCaseE = 1'b0; FlushE = 1'b0; StallM = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), 32'(0));
        reset = 1'b0;
        #1;
        chk("post_reset_outs", all_outs(), 32'(0));

        run_op("dp",    52, 1'b0, 0,  1'b0, 0);
        run_op("sp",    23, 1'b0, 0,  1'b0, 0);
        run_op("hp",    10, 1'b0, 0,  1'b0, 0);
        run_op("int64", 52, 1'b1, 64, 1'b0, 0);
        run_op("int1",  52, 1'b1, 1,  1'b0, 0);
        run_op("int0",  52, 1'b1, 0,  1'b0, 0);
        run_op("spec",  52, 1'b0, 0,  1'b1, 0);
        run_op("stall", 10, 1'b0, 0,  1'b0, 3);
        run_op("spec_stall", 23, 1'b0, 0, 1'b1, 2);

        // flush at the 5th of 14 iterations
        @(negedge clk);
        Nf = 6'd52; IntDivE = 1'b0; SpecialCaseE = 1'b0; StartE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        repeat (4) @(negedge clk);
        chk("flush.iter5_stepcnt", 32'(StepCnt), 32'(10));
        chk("flush.iter5_iteren", 32'(IterEnE), 32'(1));
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0;
        #1;
        chk("flush.idle", all_outs(), 32'(0));
        dones = 0;
        repeat (16) begin
            @(negedge clk);
            if (FDivDoneE !== 1'b0) dones++;
        end
        chk("flush.no_done", 32'(dones), 32'(0));

        // flush beats a simultaneous start
        @(negedge clk);
        Nf = 6'd23; StartE = 1'b1; FlushE = 1'b1;
        #1;
        chk("flush_start.divstart", 32'(DivStartE), 32'(0));
        @(negedge clk);
        StartE = 1'b0; FlushE = 1'b0;
        #1;
        chk("flush_start.idle", all_outs(), 32'(0));

        // flush beats a stall in DONE
        @(negedge clk);
        SpecialCaseE = 1'b1; StartE = 1'b1;
        @(negedge clk);
        SpecialCaseE = 1'b0; StartE = 1'b0; StallM = 1'b1;
        #1;
        chk("flush_stall.done", 32'({FDivDoneE, FDivBusyE}), 32'(3));
        FlushE = 1'b1;
        @(negedge clk);
        FlushE = 1'b0; StallM = 1'b0;
        #1;
        chk("flush_stall.idle", all_outs(), 32'(0));

        // async reset in the middle of BUSY
        @(negedge clk);
        Nf = 6'd23; IntDivE = 1'b0; StartE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid.iteren", 32'(IterEnE), 32'(1));
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.outs", all_outs(), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (FDivDoneE !== 1'b0 || IterEnE !== 1'b0) dones++;
        end
        chk("rst_mid.quiet", 32'(dones), 32'(0));

        for (int i = 0; i < 20; i++) begin
            run_op($sformatf("rnd%0d", i),
                   int'($urandom_range(63, 0)),
                   1'($urandom),
                   int'($urandom_range(64, 0)),
                   ($urandom_range(7, 0) == 0),
                   int'($urandom_range(2, 0)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
